// File: rtl/spike_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spike_gen_pkg                                                        |
// | Shared widths, per-generator entry layout and sweep FSM states.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package spike_gen_pkg;

  localparam int unsigned c_NGENS   = 8;
  localparam int unsigned c_NPERIOD = 16;
  localparam int unsigned c_NTAG    = 11;
  localparam int unsigned c_NCT     = 9;

  typedef struct packed {
    logic [c_NPERIOD-1:0] period;
    logic [c_NPERIOD-1:0] ticks;
    logic [c_NTAG-1:0]    tag;
    logic [c_NCT-1:0]     ct;
  } gen_entry_t;

  localparam int unsigned c_ENTRY_W = $bits(gen_entry_t);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_RD    = 3'd2,
    S_EVAL  = 3'd3,
    S_EMIT  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spike_gen_state_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spike_gen_state_mem                                                  |
// | Generator state memory: one registered read port, one write port.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module spike_gen_state_mem
  import spike_gen_pkg::*;
#(
  parameter int unsigned NGENS = c_NGENS,
  parameter int unsigned WIDTH = c_ENTRY_W
) (
  input  logic             clk,
  input  logic [NGENS-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [NGENS-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  // No reset: contents are zeroed by the owner's clear sweep.
  logic [WIDTH-1:0] r_mem [(1<<NGENS)];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/spike_gen_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spike_gen_array                                                      |
// | Time-multiplexed bank of periodic spike generators, swept once per   |
// | time unit, with programming port, backpressured output and overrun.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module spike_gen_array
  import spike_gen_pkg::*;
#(
  // Field widths must match gen_entry_t in spike_gen_pkg.
  parameter int unsigned NGENS   = c_NGENS,
  parameter int unsigned NPERIOD = c_NPERIOD,
  parameter int unsigned NTAG    = c_NTAG,
  parameter int unsigned NCT     = c_NCT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  time_unit_pulse,
  input  logic [NGENS-1:0]      gens_used,
  input  logic [(1<<NGENS)-1:0] gens_en,
  input  logic [NGENS-1:0]      prog_gen_idx,
  input  logic [NPERIOD-1:0]    prog_period,
  input  logic [NPERIOD-1:0]    prog_ticks,
  input  logic [NTAG-1:0]       prog_tag,
  input  logic [NCT-1:0]        prog_ct,
  input  logic                  prog_v,
  output logic                  prog_a,
  output logic [NTAG-1:0]       out_tag,
  output logic [NCT-1:0]        out_ct,
  output logic                  out_v,
  input  logic                  out_a,
  output logic                  overrun
);

  localparam logic [NGENS-1:0]   c_IDX_ONE = NGENS'(1);
  localparam logic [NPERIOD-1:0] c_TCK_ONE = NPERIOD'(1);

  state_t             r_state;
  logic [NGENS-1:0]   r_idx;
  logic [NGENS-1:0]   r_sweep_max;
  logic               r_pending;

  logic [c_ENTRY_W-1:0] w_rd_data;
  gen_entry_t           w_rd_entry;
  gen_entry_t           w_wr_entry;
  logic                 w_we;
  logic [NGENS-1:0]     w_wr_addr;
  logic                 w_consume;
  logic                 w_prog_fire;
  logic                 w_active;
  logic                 w_last;
  logic                 w_fire_emit;

  assign w_rd_entry  = gen_entry_t'(w_rd_data);
  assign w_consume   = (r_state == S_IDLE) && r_pending;
  assign prog_a      = (r_state == S_IDLE) && !r_pending;
  assign w_prog_fire = prog_v && prog_a;
  assign w_active    = gens_en[r_idx] && (w_rd_entry.period != '0);
  assign w_last      = (r_idx == r_sweep_max);
  assign w_fire_emit = (r_state == S_EVAL) && w_active && (w_rd_entry.ticks == '0);

  // Write port: clear sweep, host programming in IDLE, countdown writeback in EVAL.
  always_comb begin
    w_we       = 1'b0;
    w_wr_addr  = r_idx;
    w_wr_entry = '0;
    case (r_state)
      S_CLEAR: w_we = 1'b1;
      S_IDLE: begin
        if (w_prog_fire) begin
          w_we              = 1'b1;
          w_wr_addr         = prog_gen_idx;
          w_wr_entry.period = prog_period;
          w_wr_entry.ticks  = prog_ticks;
          w_wr_entry.tag    = prog_tag;
          w_wr_entry.ct     = prog_ct;
        end
      end
      S_EVAL: begin
        if (w_active) begin
          w_we       = 1'b1;
          w_wr_entry = w_rd_entry;
          if (w_rd_entry.ticks == '0) w_wr_entry.ticks = w_rd_entry.period - c_TCK_ONE;
          else                        w_wr_entry.ticks = w_rd_entry.ticks - c_TCK_ONE;
        end
      end
      default: ;
    endcase
  end

  spike_gen_state_mem #(
    .NGENS (NGENS),
    .WIDTH (c_ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .rd_addr (r_idx),
    .rd_data (w_rd_data),
    .wr_en   (w_we),
    .wr_addr (w_wr_addr),
    .wr_data (w_wr_entry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_CLEAR;
      r_idx       <= '0;
      r_sweep_max <= '0;
      r_pending   <= 1'b0;
      overrun     <= 1'b0;
      out_v       <= 1'b0;
      out_tag     <= '0;
      out_ct      <= '0;
    end else begin
      // One pulse may be queued; a pulse that finds the slot occupied is lost.
      r_pending <= time_unit_pulse || (r_pending && !w_consume);
      if (time_unit_pulse && r_pending && !w_consume) overrun <= 1'b1;

      case (r_state)
        S_CLEAR: begin
          if (&r_idx) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + c_IDX_ONE;
          end
        end
        S_IDLE: begin
          if (r_pending) begin
            r_sweep_max <= gens_used;
            r_idx       <= '0;
            r_state     <= S_RD;
          end
        end
        S_RD: r_state <= S_EVAL;
        S_EVAL: begin
          if (w_fire_emit) begin
            out_v   <= 1'b1;
            out_tag <= w_rd_entry.tag;
            out_ct  <= w_rd_entry.ct;
            r_state <= S_EMIT;
          end else if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + c_IDX_ONE;
            r_state <= S_RD;
          end
        end
        S_EMIT: begin
          if (out_a) begin
            out_v <= 1'b0;
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + c_IDX_ONE;
              r_state <= S_RD;
            end
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spike_gen_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spike_gen_array                                                   |
// | Scoreboard bench: a per-sweep reference model queues expected words; |
// | a monitor pops and compares on every output handshake.               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_spike_gen_array;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         time_unit_pulse = 1'b0;
  logic [7:0]   gens_used = '0;
  logic [255:0] gens_en = '0;
  logic [7:0]   prog_gen_idx = '0;
  logic [15:0]  prog_period = '0;
  logic [15:0]  prog_ticks = '0;
  logic [10:0]  prog_tag = '0;
  logic [8:0]   prog_ct = '0;
  logic         prog_v = 1'b0;
  logic         prog_a;
  logic [10:0]  out_tag;
  logic [8:0]   out_ct;
  logic         out_v;
  logic         out_a = 1'b0;
  logic         overrun;

  spike_gen_array dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .time_unit_pulse (time_unit_pulse),
    .gens_used       (gens_used),
    .gens_en         (gens_en),
    .prog_gen_idx    (prog_gen_idx),
    .prog_period     (prog_period),
    .prog_ticks      (prog_ticks),
    .prog_tag        (prog_tag),
    .prog_ct         (prog_ct),
    .prog_v          (prog_v),
    .prog_a          (prog_a),
    .out_tag         (out_tag),
    .out_ct          (out_ct),
    .out_v           (out_v),
    .out_a           (out_a),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_emit   = 0;
  int a_mode   = 1;  // 0: out_a low, 1: high, 2: random

  // Reference model: generator table and expected output words.
  logic [15:0] m_period [256];
  logic [15:0] m_ticks  [256];
  logic [10:0] m_tag    [256];
  logic [8:0]  m_ct     [256];
  logic [19:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      m_period[i] = '0; m_ticks[i] = '0; m_tag[i] = '0; m_ct[i] = '0;
    end
    exp_q.delete();
  endtask

  // One time unit: every enabled, nonzero-period generator up to gens_used
  // counts down; on reaching zero it emits and restarts a full period.
  task automatic model_sweep();
    for (int i = 0; i <= int'(gens_used); i++) begin
      if (gens_en[i] && m_period[i] != 0) begin
        if (m_ticks[i] == 0) begin
          exp_q.push_back({m_tag[i], m_ct[i]});
          m_ticks[i] = m_period[i] - 16'd1;
        end else begin
          m_ticks[i] = m_ticks[i] - 16'd1;
        end
      end
    end
  endtask

  task automatic pulse(input bit counted);
    @(posedge clk); #1 time_unit_pulse = 1'b1;
    @(posedge clk); #1 time_unit_pulse = 1'b0;
    if (counted) model_sweep();
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((prog_a && !out_v) || n > bound) break;
      n++;
    end
    if (!(prog_a && !out_v)) check({name, "_timeout"}, 32'(prog_a), 32'(1));
  endtask

  task automatic wait_out_v(input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (out_v || n > 2000) break;
      n++;
    end
    if (!out_v) check({name, "_timeout"}, 32'(out_v), 32'(1));
  endtask

  task automatic prog(input int idx, input logic [15:0] per, input logic [15:0] tk,
                      input logic [10:0] tg, input logic [8:0] c);
    int n = 0;
    @(posedge clk); #1;
    prog_v = 1'b1; prog_gen_idx = 8'(idx); prog_period = per;
    prog_ticks = tk; prog_tag = tg; prog_ct = c;
    forever begin
      @(negedge clk);
      if (prog_a || n > 3000) break;
      n++;
    end
    if (!prog_a) check("prog_timeout", 32'(prog_a), 32'(1));
    @(posedge clk); #1 prog_v = 1'b0;
    m_period[idx] = per; m_ticks[idx] = tk; m_tag[idx] = tg; m_ct[idx] = c;
  endtask

  task automatic check_clear(input string name);
    int bad = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (prog_a) bad++;
    end
    check({name, "_prog_a_low"}, 32'(bad), 32'(0));
    @(negedge clk);
    check({name, "_prog_a_idle"}, 32'(prog_a), 32'(1));
  endtask

  // out_a driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (a_mode)
        0:       out_a = 1'b0;
        1:       out_a = 1'b1;
        default: out_a = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: stability while stalled, compare on each handshake.
  initial begin
    logic        stalled;
    logic [19:0] held;
    logic [19:0] e;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_v", 32'(out_v), 32'(1));
          check("hold_data", 32'({out_tag, out_ct}), 32'(held));
        end
        if (out_v && out_a) begin
          n_emit++;
          if (exp_q.size() == 0) begin
            check("unexpected_emit", 32'({out_tag, out_ct}), 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            check("emit_word", 32'({out_tag, out_ct}), 32'(e));
          end
          stalled = 1'b0;
        end else if (out_v) begin
          stalled = 1'b1;
          held = {out_tag, out_ct};
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    int e0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_out_v", 32'(out_v), 32'(0));
    check("rst_out_word", 32'({out_tag, out_ct}), 32'(0));
    check("rst_prog_a", 32'(prog_a), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    reset_n = 1'b1;
    check_clear("init");

    // Single generator, period 4: emits on pulses 1, 5, 9.
    gens_used = 8'd7; gens_en[3] = 1'b1; a_mode = 1;
    prog(3, 16'd4, 16'd0, 11'h155, 9'd2);
    e0 = n_emit;
    for (int p = 0; p < 9; p++) begin
      pulse(1'b1);
      wait_idle("t1", 2000);
    end
    check("t1_emits", 32'(n_emit - e0), 32'(3));
    check("t1_q_empty", 32'(exp_q.size()), 32'(0));

    // Freeze entry 3 for three time units, then resume.
    e0 = n_emit;
    gens_en[3] = 1'b0;
    for (int p = 0; p < 3; p++) begin pulse(1'b1); wait_idle("t2a", 2000); end
    gens_en[3] = 1'b1;
    for (int p = 0; p < 5; p++) begin pulse(1'b1); wait_idle("t2b", 2000); end
    check("t2_emits", 32'(n_emit - e0), 32'(1));

    // Two period-1 entries with a 10-cycle output stall.
    prog(0, 16'd1, 16'd0, 11'h0A5, 9'h1C3);
    prog(1, 16'd1, 16'd0, 11'h35A, 9'h03C);
    gens_en[1:0] = 2'b11;
    a_mode = 0;
    pulse(1'b1);
    wait_out_v("t3");
    repeat (10) @(negedge clk);
    a_mode = 1;
    wait_idle("t3", 2000);
    check("t3_q_empty", 32'(exp_q.size()), 32'(0));

    // period 0 never emits; programming during a sweep waits for IDLE.
    prog(5, 16'd0, 16'd0, 11'h7FF, 9'h1FF);
    gens_en[6:5] = 2'b11;
    pulse(1'b1);
    @(negedge clk);
    check("t4_prog_a_busy", 32'(prog_a), 32'(0));
    prog(6, 16'd2, 16'd0, 11'h123, 9'h045);
    wait_idle("t4a", 2000);
    for (int p = 0; p < 3; p++) begin pulse(1'b1); wait_idle("t4b", 2000); end
    check("t4_q_empty", 32'(exp_q.size()), 32'(0));

    // Pulses every 2 cycles over a full 256-entry sweep.
    gens_used = 8'd255;
    check("t5_overrun_pre", 32'(overrun), 32'(0));
    pulse(1'b1);
    pulse(1'b1);
    check("t5_overrun_queued", 32'(overrun), 32'(0));
    pulse(1'b0);
    check("t5_overrun_set", 32'(overrun), 32'(1));
    wait_idle("t5", 4000);
    check("t5_overrun_sticky", 32'(overrun), 32'(1));
    check("t5_q_empty", 32'(exp_q.size()), 32'(0));

    // Randomized table, enables and backpressure.
    a_mode = 2;
    for (int k = 0; k < 10; k++)
      prog($urandom_range(0, 15), 16'($urandom_range(0, 6)), 16'($urandom_range(0, 8)),
           11'($urandom), 9'($urandom));
    gens_en[15:0] = 16'($urandom);
    gens_used = 8'($urandom_range(0, 15));
    for (int p = 0; p < 12; p++) begin pulse(1'b1); wait_idle("t6", 3000); end
    check("t6_q_empty", 32'(exp_q.size()), 32'(0));
    check("t6_overrun_sticky", 32'(overrun), 32'(1));

    // Reset in the middle of a stalled emission.
    a_mode = 0;
    gens_used = 8'd0; gens_en[0] = 1'b1;
    prog(0, 16'd1, 16'd0, 11'h2AA, 9'h0AA);
    pulse(1'b1);
    wait_out_v("t7");
    #2 reset_n = 1'b0;
    #1 check("t7_out_v_async", 32'(out_v), 32'(0));
    check("t7_overrun_clr", 32'(overrun), 32'(0));
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    check_clear("t7");
    a_mode = 1;
    gens_en = '1; gens_used = 8'd255;
    e0 = n_emit;
    for (int p = 0; p < 2; p++) begin pulse(1'b1); wait_idle("t7", 3000); end
    check("t7_no_emits", 32'(n_emit - e0), 32'(0));
    check("t7_q_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_gen_array.md
# spike_gen_array

Time-multiplexed bank of up to 2**Ngens periodic spike generators. It sits between the host-decoded programming stream and the upstream tag/count merge. Per-generator state (period, countdown, tag, count) lives in a small state memory that is swept once per FPGA time unit. Compared with the single-config generator bundle, it adds a per-generator count field, phase programming, backpressure-aware emission, post-reset memory clearing, and overrun detection.

## Interface
- Ngens, 8, generator index width; bank holds 2**Ngens entries
- Nperiod, 16, period/countdown width
- Ntag, 11, output tag width
- Nct, 9, output count width
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- time_unit_pulse  in  1  one-cycle strobe per time unit, from the time manager
- gens_used  in  Ngens  highest generator index swept
- gens_en  in  2**Ngens  per-generator enable
- prog_gen_idx  in  Ngens  programming channel: target entry
- prog_period  in  Nperiod  programming channel: period in time units; 0 disables the entry
- prog_ticks  in  Nperiod  programming channel: initial countdown (phase)
- prog_tag  in  Ntag  programming channel: tag emitted
- prog_ct  in  Nct  programming channel: count emitted with tag
- prog_v / prog_a  in / out  1 / 1  programming handshake
- out_tag / out_ct  out  Ntag / Nct  emitted tag/count
- out_v / out_a  out / in  1 / 1  output handshake
- overrun  out  1  sticky; set when a time unit is dropped; cleared only by reset

## Operation
- States: CLEAR, IDLE, RD, EVAL, EMIT.
- Reset puts the FSM in CLEAR with idx=0.
- CLEAR: writes an all-zero entry at idx each cycle, for 2**Ngens cycles, then goes to IDLE.
- IDLE:
  - prog_a=1. A prog handshake (v&a) writes {period, ticks, tag, ct} to entry prog_gen_idx.
  - A pending pulse (pending=1) has priority over programming in the same cycle: prog_a=0, clear pending, latch gens_used into sweep_max, set idx=0, go to RD.
- RD: present idx to the memory read port.
- EVAL: read data is valid; the entry counts as active when gens_en[idx] is set and period≠0.
  - Inactive: no write; countdown frozen.
  - Active, ticks≠0: write back ticks-1.
  - Active, ticks==0: write back ticks=period-1, load out_tag/out_ct from the entry, raise out_v, go to EMIT.
  - When not entering EMIT: if idx==sweep_max go to IDLE, otherwise idx+1 and go to RD.
- EMIT: hold out_v and data stable until out_a. In the cycle out_a is seen, drop out_v and advance as EVAL would.
- pending flag:
  - Set by time_unit_pulse in any state.
  - If pending is already 1 when a pulse arrives (and is not being consumed that cycle), set overrun. Only one pulse is queued; further pulses are dropped.
- Programming during CLEAR/RD/EVAL/EMIT: prog_a=0, and the request waits.
- Arithmetic: ticks-1 never underflows (the ticks==0 branch reloads). period-1 uses Nperiod-bit unsigned arithmetic. period=1 emits every time unit.
- prog_ticks ≥ prog_period is legal: the first emission is delayed, then the entry settles to the normal period.
- gens_used changes during a sweep take effect at the next sweep. gens_en is sampled live in EVAL.

## Timing
- Reset values:
  - out_v=0, out_tag=0, out_ct=0, prog_a=0, overrun=0, pending=0.
  - All entries read as zero once CLEAR completes, 2**Ngens cycles after reset_n rises.
- Memory read latency is 1 cycle. The write port commits at the clock edge ending EVAL/EMIT.
- Sweep cost: 2 cycles per entry without emission. An emitting entry costs 3 cycles plus backpressure stall cycles.
- A pulse seen in IDLE gives first RD in the next cycle. The first emission for entry 0 is raised 3 cycles after the pulse edge.
- out_v rises only on entry to EMIT. Data stays stable while out_v&!out_a.
- Reset mid-sweep aborts the sweep immediately: out_v drops asynchronously and CLEAR restarts.

## Structure
- Shared package spike_gen_pkg holds:
  - typedef gen_entry_t {period, ticks, tag, ct};
  - the FSM state enum;
  - the entry-width constant.
- Sub-module spike_gen_state_mem: 2**Ngens × gen_entry_t, 1 registered read port, 1 write port, no reset (cleared by the CLEAR state).
- The FSM, pending/overrun logic, write-port mux (clear/program/writeback) and output register sit in the top module.

## Test plan
- Reset, then program entry 3 with period=4, ticks=0, tag=0x155, ct=2, gens_en[3]=1, gens_used=7, out_a=1 constant. Expect emissions of {0x155,2} on pulses 1, 5, 9; no other outputs.
- Entries 0 and 1 both with period=1, out_a held low for 10 cycles. Expect entry 0's word held stable through the stall, then entry 1 follows in the same sweep. No loss.
- Pulses every 2 cycles with gens_used=255. Expect overrun=1 after the second extra pulse, and the sweep completes. overrun stays 1 until reset.
- gens_en[3] cleared for 3 pulses, then set again. Expect the countdown to resume from its frozen value; entry period=4 phase shifts by 3 units.
- Program with period=0. Expect no emission ever. prog_v asserted during a sweep: expect prog_a=0 until IDLE, and the write to land afterward.
- Assert reset_n low mid-EMIT. Expect out_v=0 at once, prog_a=0 for 256 cycles, and all entries reading zero afterwards.
